// File: rtl/bus_master_port.sv
// bus_master_port: master endpoint of the serial system bus.
// Serialises single-byte read/write requests (address then write data,
// LSB first) over a valid/ready lane and deserialises the returned read byte.
module bus_master_port #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m_start,
  input  logic              m_mode,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wr_data,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              m_wr_en,
  output logic              mode,
  output logic              wr_bus,
  output logic              master_valid,
  input  logic              slave_ready,
  input  logic              rd_bus,
  input  logic              slave_valid,
  output logic              master_ready
);

  localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(MAX_W);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t            r_state;
  // Bits not yet placed on wr_bus (the bit currently on the lane is already shifted out).
  logic [ADDR_W-1:0] r_addr_sh;
  logic [DATA_W-1:0] r_data_sh;
  // First DATA_W-1 received bits; the last bit is taken straight from rd_bus.
  logic [DATA_W-2:0] r_rd_sh;
  logic [CNT_W-1:0]  r_cnt;

  logic w_wr_xfer;
  logic w_rd_xfer;

  assign w_wr_xfer = master_valid & slave_ready;
  assign w_rd_xfer = master_ready & slave_valid;

  // Transaction FSM: all bus and initiator-facing outputs are registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_addr_sh    <= '0;
      r_data_sh    <= '0;
      r_rd_sh      <= '0;
      r_cnt        <= '0;
      m_rd_data    <= '0;
      m_wr_en      <= 1'b0;
      mode         <= 1'b0;
      wr_bus       <= 1'b0;
      master_valid <= 1'b0;
      master_ready <= 1'b0;
    end else begin
      m_wr_en <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (m_start) begin
            mode         <= m_mode;
            r_addr_sh    <= m_addr >> 1;
            r_data_sh    <= m_wr_data;
            wr_bus       <= m_addr[0];
            master_valid <= 1'b1;
            r_cnt        <= '0;
            r_state      <= ADDR;
          end
        end
        ADDR: begin
          if (w_wr_xfer) begin
            if (r_cnt == ADDR_LAST) begin
              r_cnt <= '0;
              if (mode) begin
                wr_bus    <= r_data_sh[0];
                r_data_sh <= r_data_sh >> 1;
                r_state   <= WDATA;
              end else begin
                wr_bus       <= 1'b0;
                master_valid <= 1'b0;
                master_ready <= 1'b1;
                r_state      <= RDATA;
              end
            end else begin
              wr_bus    <= r_addr_sh[0];
              r_addr_sh <= r_addr_sh >> 1;
              r_cnt     <= r_cnt + CNT_W'(1);
            end
          end
        end
        WDATA: begin
          if (w_wr_xfer) begin
            if (r_cnt == DATA_LAST) begin
              r_cnt        <= '0;
              wr_bus       <= 1'b0;
              master_valid <= 1'b0;
              r_state      <= IDLE;
            end else begin
              wr_bus    <= r_data_sh[0];
              r_data_sh <= r_data_sh >> 1;
              r_cnt     <= r_cnt + CNT_W'(1);
            end
          end
        end
        RDATA: begin
          if (w_rd_xfer) begin
            if (r_cnt == DATA_LAST) begin
              m_rd_data    <= {rd_bus, r_rd_sh};
              m_wr_en      <= 1'b1;
              master_ready <= 1'b0;
              r_cnt        <= '0;
              r_state      <= IDLE;
            end else begin
              r_rd_sh <= {rd_bus, r_rd_sh[DATA_W-2:1]};
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: table-driven and randomized checks of bus_master_port
// against a memory-level reference model, with a behavioural slave peer.
module tb_bus_master_port;

  logic        clk;
  logic        rstn;
  logic        m_start;
  logic        m_mode;
  logic [15:0] m_addr;
  logic [7:0]  m_wr_data;
  logic [7:0]  m_rd_data;
  logic        m_wr_en;
  logic        mode;
  logic        wr_bus;
  logic        master_valid;
  logic        slave_ready;
  logic        rd_bus;
  logic        slave_valid;
  logic        master_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave peer storage (filled from bits seen on the bus) and reference model
  // storage (filled from the requests issued).
  logic [7:0] slave_mem [logic [15:0]];
  logic [7:0] model_mem [logic [15:0]];

  typedef struct {
    bit          md;
    logic [15:0] a;
    logic [7:0]  d;
    int          stall;
    bit          busy;
    logic [7:0]  exp_rd;
    int          exp_vc;
  } vec_t;

  vec_t vecs [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_master_port #(
    .ADDR_W(16),
    .DATA_W(8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m_start      (m_start),
    .m_mode       (m_mode),
    .m_addr       (m_addr),
    .m_wr_data    (m_wr_data),
    .m_rd_data    (m_rd_data),
    .m_wr_en      (m_wr_en),
    .mode         (mode),
    .wr_bus       (wr_bus),
    .master_valid (master_valid),
    .slave_ready  (slave_ready),
    .rd_bus       (rd_bus),
    .slave_valid  (slave_valid),
    .master_ready (master_ready)
  );

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request starting at the current negedge and plays the slave.
  // stall: 0 = ready always high, 1 = ready toggles (low first), 2 = random.
  task automatic run_txn(input bit md, input logic [15:0] a, input logic [7:0] d,
                         input int stall, input bit busy,
                         input logic [7:0] exp_rd, input int exp_vc);
    logic [23:0] got;
    logic [15:0] saddr;
    logic [7:0]  rbyte;
    logic [7:0]  got_rd;
    int          nbits, vc, pulses, rbit, cyc, viol, extra;
    bit          done, tog, rdy, prev_stall, prev_bit;
    got = '0; saddr = '0; rbyte = '0; got_rd = '0;
    nbits = 0; vc = 0; pulses = 0; rbit = 0; cyc = 0; viol = 0; extra = 0;
    done = 1'b0; tog = 1'b0; rdy = 1'b0; prev_stall = 1'b0; prev_bit = 1'b0;

    m_start = 1'b1; m_mode = md; m_addr = a; m_wr_data = d;
    slave_ready = 1'b0; slave_valid = 1'b0; rd_bus = 1'b0;
    @(negedge clk);
    m_start = 1'b0; m_mode = 1'($urandom); m_addr = 16'($urandom); m_wr_data = 8'($urandom);
    chk("mode_after_start", mode, md);

    while (!done && cyc < 400) begin
      if (master_valid) vc++;
      if (master_valid && master_ready) viol++;
      if (prev_stall && master_valid && (wr_bus !== prev_bit)) viol++;
      if (m_wr_en) begin
        pulses++;
        got_rd = m_rd_data;
      end
      if (md) done = (nbits >= 24) && !master_valid;
      else    done = (pulses > 0);
      if (!done) begin
        if (stall == 0) rdy = 1'b1;
        else if (stall == 1) begin
          rdy = tog;
          tog = !tog;
        end else rdy = ($urandom_range(0, 3) != 0);
        if (busy && cyc == 5) begin
          m_start = 1'b1; m_mode = !md; m_addr = a ^ 16'hFFFF; m_wr_data = ~d;
        end
        if (busy && cyc == 6) m_start = 1'b0;
        slave_ready = rdy;
        slave_valid = rdy;
        rd_bus      = 1'b0;
        prev_stall  = master_valid && !rdy;
        prev_bit    = wr_bus;
        if (master_valid && rdy) begin
          if (nbits < 24) got[nbits] = wr_bus;
          nbits++;
          if (nbits == 16) begin
            saddr = got[15:0];
            rbyte = slave_mem.exists(saddr) ? slave_mem[saddr] : dflt(saddr);
          end
          if (nbits == 24) slave_mem[got[15:0]] = got[23:16];
        end
        if (master_ready && rdy && rbit < 8) begin
          rd_bus = rbyte[rbit];
          rbit++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    slave_ready = 1'b0; slave_valid = 1'b0; rd_bus = 1'b0; m_start = 1'b0;

    chk("txn_done", done, 1'b1);
    chk("bits_sent", nbits, md ? 24 : 16);
    chk("addr_bits", got[15:0], a);
    if (md) chk("wdata_bits", got[23:16], d);
    chk("wr_en_pulses", pulses, md ? 0 : 1);
    if (!md) chk("rd_data", got_rd, exp_rd);
    if (exp_vc >= 0) chk("valid_cycles", vc, exp_vc);
    chk("protocol", viol, 0);
    chk("mode_hold", mode, md);
    chk("handshake_idle", {master_valid, master_ready}, 2'b00);
    if (!md) begin
      @(negedge clk);
      chk("wr_en_width", m_wr_en, 1'b0);
      chk("rd_data_hold", m_rd_data, exp_rd);
    end
    if (busy) begin
      for (int i = 0; i < 3; i++) begin
        if (master_valid || master_ready) extra++;
        @(negedge clk);
      end
      chk("no_second_txn", extra, 0);
    end
  endtask

  initial begin
    vecs[0] = '{md: 1'b1, a: 16'hF234, d: 8'h5A, stall: 0, busy: 1'b0, exp_rd: 8'h00, exp_vc: 24};
    vecs[1] = '{md: 1'b0, a: 16'hF234, d: 8'h00, stall: 0, busy: 1'b0, exp_rd: 8'h5A, exp_vc: 16};
    vecs[2] = '{md: 1'b1, a: 16'hF234, d: 8'h5A, stall: 1, busy: 1'b0, exp_rd: 8'h00, exp_vc: 48};
    vecs[3] = '{md: 1'b1, a: 16'h1234, d: 8'hC3, stall: 0, busy: 1'b1, exp_rd: 8'h00, exp_vc: 24};
    vecs[4] = '{md: 1'b0, a: 16'h1234, d: 8'h00, stall: 1, busy: 1'b0, exp_rd: 8'hC3, exp_vc: 32};
    vecs[5] = '{md: 1'b0, a: 16'h0BAD, d: 8'h00, stall: 0, busy: 1'b0, exp_rd: 8'h08, exp_vc: 16};

    rstn = 1'b0; m_start = 1'b0; m_mode = 1'b0; m_addr = '0; m_wr_data = '0;
    slave_ready = 1'b0; rd_bus = 1'b0; slave_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_master_valid", master_valid, 1'b0);
    chk("rst_master_ready", master_ready, 1'b0);
    chk("rst_wr_bus", wr_bus, 1'b0);
    chk("rst_mode", mode, 1'b0);
    chk("rst_m_wr_en", m_wr_en, 1'b0);
    chk("rst_m_rd_data", m_rd_data, 8'h00);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_no_start", {master_valid, master_ready, m_wr_en}, 3'b000);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].md) model_mem[vecs[i].a] = vecs[i].d;
      run_txn(vecs[i].md, vecs[i].a, vecs[i].d, vecs[i].stall, vecs[i].busy,
              vecs[i].exp_rd, vecs[i].exp_vc);
    end

    // Reset in the middle of the read-data phase.
    begin
      int w;
      w = 0;
      m_start = 1'b1; m_mode = 1'b0; m_addr = 16'hF234;
      @(negedge clk);
      m_start = 1'b0;
      while (!master_ready && w < 40) begin
        slave_ready = 1'b1;
        @(negedge clk);
        w++;
      end
      slave_ready = 1'b0;
      chk("rstmid_reached_rdata", master_ready, 1'b1);
      slave_valid = 1'b1; rd_bus = 1'b1;
      repeat (2) @(negedge clk);
      slave_valid = 1'b0; rd_bus = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk("rstmid_master_ready", master_ready, 1'b0);
      chk("rstmid_master_valid", master_valid, 1'b0);
      chk("rstmid_wr_bus", wr_bus, 1'b0);
      chk("rstmid_m_rd_data", m_rd_data, 8'h00);
      chk("rstmid_m_wr_en", m_wr_en, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
    end
    model_mem[16'hF234] = 8'h96;
    run_txn(1'b1, 16'hF234, 8'h96, 0, 1'b0, 8'h00, 24);
    run_txn(1'b0, 16'hF234, 8'h00, 0, 1'b0, 8'h96, 16);

    for (int i = 0; i < 40; i++) begin
      bit          md;
      logic [15:0] a;
      logic [7:0]  d;
      logic [7:0]  e;
      md = 1'($urandom_range(0, 1));
      a  = 16'h3C00 | 16'($urandom_range(0, 7));
      d  = 8'($urandom);
      e  = model_read(a);
      if (md) model_mem[a] = d;
      run_txn(md, a, d, 2, 1'b0, e, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
